reg_pair_sequencer: RTL and testbench
=====================================

Name: reg_pair_sequencer

Overview:
Command sequencer that sits directly upstream of the A/B register pair. It accepts one command at a time over a valid/ready handshake and drives the shared data bus and the active-low register write enables. It reads the register outputs back for arithmetic and swap. It supplies each write strobe and data word the register pair consumes.

Parameters:
WIDTH, 4, width of data bus, immediates and register read-back ports.

Ports:
Clock  input  1  single clock; all state updates on rising edge
Resetn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  sequencer can accept a command (high only in IDLE)
cmd_op  input  2  opcode: 00 LDA, 01 LDB, 10 ADD, 11 SWP
cmd_data  input  WIDTH  immediate for LDA/LDB; ignored otherwise
RegAQ  input  WIDTH  current contents of register A
RegBQ  input  WIDTH  current contents of register B
DBUS  output  WIDTH  data bus to both registers
RegAWn  output  1  active-low write enable, register A
RegBWn  output  1  active-low write enable, register B
done  output  1  one-cycle pulse when a command completes
carry  output  1  carry-out of the last ADD

Behaviour:
- Reset (async, Resetn=0): state IDLE; DBUS=0; RegAWn=RegBWn=1; done=0; carry=0; operand/temp registers=0. Reset mid-command abandons the command with no further write strobe. The strobe drops immediately (asynchronously).
- All outputs are registered or decoded from registered state only; no combinational path from cmd_* to DBUS, Wn or done.
- States: IDLE, W1, W2, DONE.
- IDLE: cmd_ready=1, DBUS=0, Wn both high. Accept on the rising edge where cmd_valid & cmd_ready.
  - At the accept edge, latch cmd_op and cmd_data.
  - At the accept edge, snapshot RegAQ into opA and RegBQ into opB.
  - Go to W1.
- W1 (one cycle), by opcode:
  - LDA: DBUS=imm, RegAWn=0.
  - LDB: DBUS=imm, RegBWn=0.
  - ADD: DBUS=(opA+opB) mod 2^WIDTH, RegAWn=0. carry takes the bit-WIDTH carry-out on the edge leaving W1.
  - SWP: DBUS=opA, RegBWn=0.
  - Next state: SWP goes to W2; all other opcodes go to DONE.
- W2 (SWP only, one cycle): DBUS=opB, RegAWn=0 → DONE.
- DONE (one cycle): done=1, Wn both high, DBUS holds the last value, cmd_ready=0 → IDLE.
- Strobe rules:
  - Exactly one Wn is low per write cycle, for exactly one cycle.
  - DBUS is stable for the whole strobe cycle.
  - The downstream register captures at the rising edge that ends the strobe cycle.
  - RegAWn and RegBWn are never low simultaneously.
- Latency: accept edge N.
  - LDA/LDB/ADD: strobe in cycle N+1, done in cycle N+2, ready again in cycle N+3.
  - SWP: strobes in cycles N+1 (B) and N+2 (A), done in cycle N+3, ready in cycle N+4.
- Handshake: cmd_valid while not ready is ignored; there is no queuing. The command must be held by the source until accepted.
- Operands are taken from the accept-edge snapshot. Changes on RegAQ/RegBQ after accept do not affect the command; SWP uses pre-swap values for both writes.
- carry changes only on ADD completion; LDA, LDB and SWP leave it unchanged.
- Overflow wraps modulo 2^WIDTH (e.g. WIDTH=4: 15+1 → 0, carry=1).

Decomposition:
- Shared package: opcode constants (OP_LDA=2'b00, OP_LDB=2'b01, OP_ADD=2'b10, OP_SWP=2'b11) and the state encoding (IDLE, W1, W2, DONE).
- One natural sub-module: seq_adder, a combinational WIDTH-bit adder producing sum and carry-out, instantiated once.
- The FSM and datapath registers stay in reg_pair_sequencer.

Test Plan:
1. Reset, then LDA imm=4'h9 → cmd_ready=0 next cycle; one cycle RegAWn=0 with DBUS=9; done pulse the following cycle; RegBWn stays 1 throughout.
2. A=4'h7, B=4'h5 in a register model, ADD → DBUS=4'hC with RegAWn low for 1 cycle; carry=0. Then A=4'hF, B=4'h1, ADD → DBUS=4'h0, carry=1.
3. A=3, B=A (hex), SWP → cycle N+1: RegBWn=0, DBUS=3; cycle N+2: RegAWn=0, DBUS=A; done at N+3; model ends with A=A, B=3.
4. cmd_valid held high with back-to-back LDB 1 then LDB 2 → second command accepted only when cmd_ready returns; two separate one-cycle RegBWn strobes carrying 1 then 2.
5. Assert Resetn=0 during SWP cycle W1 → RegBWn rises immediately; no RegAWn strobe; after release: IDLE, cmd_ready=1, carry=0, DBUS=0.
6. Random command stream with a register-pair model → RegAWn and RegBWn are never both low, done count equals accepted-command count, and the model matches the expected A/B values.

Source files
------------

// File: rtl/reg_pair_sequencer_pkg.sv
// reg_pair_sequencer_pkg: opcode constants and FSM state encoding shared by the sequencer slice
package reg_pair_sequencer_pkg;
  localparam logic [1:0] OP_LDA = 2'b00;
  localparam logic [1:0] OP_LDB = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SWP = 2'b11;
  typedef enum logic [1:0] {IDLE, W1, W2, DONE} state_t;
endpackage

// File: rtl/reg_pair_sequencer_if.sv
// reg_pair_sequencer_if: command handshake, register read-back and write bus of the sequencer
// master = command source / register pair side, slave = sequencer side
interface reg_pair_sequencer_if #(parameter int WIDTH = 4);
  logic cmd_valid;
  logic cmd_ready;
  logic [1:0] cmd_op;
  logic [WIDTH-1:0] cmd_data;
  logic [WIDTH-1:0] RegAQ;
  logic [WIDTH-1:0] RegBQ;
  logic [WIDTH-1:0] DBUS;
  logic RegAWn;
  logic RegBWn;
  logic done;
  logic carry;
  modport master (
    output cmd_valid, cmd_op, cmd_data, RegAQ, RegBQ,
    input cmd_ready, DBUS, RegAWn, RegBWn, done, carry
  );
  modport slave (
    input cmd_valid, cmd_op, cmd_data, RegAQ, RegBQ,
    output cmd_ready, DBUS, RegAWn, RegBWn, done, carry
  );
endinterface

// File: rtl/reg_pair_sequencer_adder.sv
// seq_adder: combinational WIDTH-bit adder; ports a, b in, sum and carry-out co out
module seq_adder #(parameter int WIDTH = 4) (
  input logic [WIDTH-1:0] a,
  input logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic co
);
  assign {co, sum} = {1'b0, a} + {1'b0, b};
endmodule

// File: rtl/reg_pair_sequencer.sv
// reg_pair_sequencer: one-command-at-a-time sequencer driving the A/B register pair
// Ports: Clock, Resetn (async active-low), bus (slave: cmd handshake, RegAQ/RegBQ in, DBUS/RegAWn/RegBWn/done/carry out)
module reg_pair_sequencer import reg_pair_sequencer_pkg::*; #(parameter int WIDTH = 4) (
  input logic Clock,
  input logic Resetn,
  reg_pair_sequencer_if.slave bus
);
  state_t state, state_nxt;
  logic [1:0] op;
  logic [WIDTH-1:0] imm, op_a, op_b, sum, w1_val;
  logic co, carry_q;
  seq_adder #(.WIDTH(WIDTH)) u_add (.a(op_a), .b(op_b), .sum(sum), .co(co));
  always_ff @(posedge Clock or negedge Resetn)
    if (!Resetn) begin
      state <= IDLE;
      op <= OP_LDA;
      imm <= '0;
      op_a <= '0;
      op_b <= '0;
      carry_q <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cmd_valid) begin
        op <= bus.cmd_op;
        imm <= bus.cmd_data;
        op_a <= bus.RegAQ;
        op_b <= bus.RegBQ;
      end
      if (state == W1 && op == OP_ADD) carry_q <= co;
    end
  always_comb
    state_nxt = state == IDLE ? (bus.cmd_valid ? W1 : IDLE) :
                state == W1 ? (op == OP_SWP ? W2 : DONE) :
                state == W2 ? DONE : IDLE;
  // Outputs decode only registered state, so the async reset drops any strobe at once.
  // In DONE the bus keeps showing the word of the final write cycle.
  always_comb begin
    w1_val = op == OP_ADD ? sum : op == OP_SWP ? op_a : imm;
    bus.DBUS = state == IDLE ? '0 :
               state == W1 ? w1_val :
               state == W2 ? op_b :
               op == OP_SWP ? op_b : w1_val;
    bus.RegAWn = !((state == W1 && (op == OP_LDA || op == OP_ADD)) || state == W2);
    bus.RegBWn = !(state == W1 && (op == OP_LDB || op == OP_SWP));
    bus.done = state == DONE;
    bus.cmd_ready = state == IDLE;
    bus.carry = carry_q;
  end
endmodule

// File: tb/tb_reg_pair_sequencer.sv
// tb_reg_pair_sequencer: randomized self-checking bench with a register-pair model and per-command expectations
module tb_reg_pair_sequencer;
  import reg_pair_sequencer_pkg::*;
  logic clk = 0;
  logic rst_n = 0;
  int vectors = 0;
  int miscompares = 0;
  int accepted = 0;
  int dones = 0;
  logic [3:0] ra = 0, rb = 0;
  logic carry_model = 0;
  reg_pair_sequencer_if #(.WIDTH(4)) bus ();
  reg_pair_sequencer #(.WIDTH(4)) dut (.Clock(clk), .Resetn(rst_n), .bus(bus));
  always #5 clk = ~clk;
  assign bus.RegAQ = ra;
  assign bus.RegBQ = rb;
  always @(posedge clk) begin
    if (!bus.RegAWn) ra <= bus.DBUS;
    if (!bus.RegBWn) rb <= bus.DBUS;
  end
  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  always @(negedge clk) begin
    chk("wn_excl", {7'd0, bus.RegAWn | bus.RegBWn}, 8'd1);
    if (bus.done === 1'b1) dones++;
  end
  task automatic do_cmd(input logic [1:0] op, input logic [3:0] d, input bit hold);
    logic [4:0] s;
    logic [3:0] ea, eb, exa, exb, last;
    logic ec;
    int n;
    bus.cmd_valid = 1;
    bus.cmd_op = op;
    bus.cmd_data = d;
    n = 0;
    while (bus.cmd_ready !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", {7'd0, n < 10}, 8'd1);
    ea = ra;
    eb = rb;
    s = {1'b0, ea} + {1'b0, eb};
    ec = carry_model;
    exa = ea;
    exb = eb;
    @(negedge clk);
    accepted++;
    if (!hold) bus.cmd_valid = 0;
    chk("busy_ready", {7'd0, bus.cmd_ready}, 8'd0);
    if (op == OP_SWP) begin
      chk("swp1_awn", {7'd0, bus.RegAWn}, 8'd1);
      chk("swp1_bwn", {7'd0, bus.RegBWn}, 8'd0);
      chk("swp1_dbus", {4'd0, bus.DBUS}, {4'd0, ea});
      @(negedge clk);
      chk("swp2_awn", {7'd0, bus.RegAWn}, 8'd0);
      chk("swp2_bwn", {7'd0, bus.RegBWn}, 8'd1);
      chk("swp2_dbus", {4'd0, bus.DBUS}, {4'd0, eb});
      exa = eb;
      exb = ea;
      last = eb;
    end else begin
      last = op == OP_ADD ? s[3:0] : d;
      if (op == OP_ADD) ec = s[4];
      if (op == OP_LDB) exb = d; else exa = last;
      chk("w1_awn", {7'd0, bus.RegAWn}, {7'd0, op == OP_LDB});
      chk("w1_bwn", {7'd0, bus.RegBWn}, {7'd0, op != OP_LDB});
      chk("w1_dbus", {4'd0, bus.DBUS}, {4'd0, last});
    end
    @(negedge clk);
    chk("done", {7'd0, bus.done}, 8'd1);
    chk("done_wn", {6'd0, bus.RegAWn, bus.RegBWn}, 8'd3);
    chk("done_ready", {7'd0, bus.cmd_ready}, 8'd0);
    chk("done_dbus", {4'd0, bus.DBUS}, {4'd0, last});
    chk("carry", {7'd0, bus.carry}, {7'd0, ec});
    chk("reg_a", {4'd0, ra}, {4'd0, exa});
    chk("reg_b", {4'd0, rb}, {4'd0, exb});
    carry_model = ec;
    @(negedge clk);
    chk("idle_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("idle_done", {7'd0, bus.done}, 8'd0);
    chk("idle_dbus", {4'd0, bus.DBUS}, 8'd0);
  endtask
  initial begin
    bus.cmd_valid = 0;
    bus.cmd_op = 0;
    bus.cmd_data = 0;
    #12;
    chk("rst_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rst_wn", {6'd0, bus.RegAWn, bus.RegBWn}, 8'd3);
    chk("rst_dbus", {4'd0, bus.DBUS}, 8'd0);
    chk("rst_done_carry", {6'd0, bus.done, bus.carry}, 8'd0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    do_cmd(OP_LDA, 4'h9, 0);
    do_cmd(OP_LDA, 4'h7, 0);
    do_cmd(OP_LDB, 4'h5, 0);
    do_cmd(OP_ADD, 4'h0, 0);
    do_cmd(OP_LDA, 4'hF, 0);
    do_cmd(OP_LDB, 4'h1, 0);
    do_cmd(OP_ADD, 4'h6, 0);
    do_cmd(OP_LDA, 4'h3, 0);
    do_cmd(OP_LDB, 4'hA, 0);
    do_cmd(OP_SWP, 4'h0, 0);
    do_cmd(OP_LDB, 4'h1, 1);
    do_cmd(OP_LDB, 4'h2, 0);
    chk("carry_before_rst", {7'd0, bus.carry}, 8'd1);
    bus.cmd_valid = 1;
    bus.cmd_op = OP_SWP;
    bus.cmd_data = 0;
    @(negedge clk);
    bus.cmd_valid = 0;
    accepted++;
    chk("rst_swp_bwn", {7'd0, bus.RegBWn}, 8'd0);
    #2 rst_n = 0;
    #1;
    chk("rst_async_bwn", {7'd0, bus.RegBWn}, 8'd1);
    chk("rst_async_awn", {7'd0, bus.RegAWn}, 8'd1);
    @(negedge clk);
    rst_n = 1;
    carry_model = 0;
    chk("rstrel_ready", {7'd0, bus.cmd_ready}, 8'd1);
    chk("rstrel_carry", {7'd0, bus.carry}, 8'd0);
    chk("rstrel_dbus", {4'd0, bus.DBUS}, 8'd0);
    chk("rstrel_a_kept", {4'd0, ra}, 8'h0A);
    chk("rstrel_b_kept", {4'd0, rb}, 8'h02);
    @(negedge clk);
    chk("rstrel_wn", {6'd0, bus.RegAWn, bus.RegBWn}, 8'd3);
    accepted--;
    for (int i = 0; i < 200; i++)
      do_cmd(2'($urandom_range(0, 3)), 4'($urandom), bit'($urandom_range(0, 1)));
    bus.cmd_valid = 0;
    @(negedge clk);
    chk("done_count", 8'(dones), 8'(accepted));
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
